// File: rtl/spawn_slot_scheduler_pkg.sv
// Shared definitions for the spawn slot scheduler: default sizing, FSM encoding and requester IDs.
package spawn_pkg;

   localparam int NSLOT_DEF    = 4;
   localparam int SLOT_W_DEF   = 2;
   localparam int COOLDOWN_DEF = 8;
   localparam int CD_W_DEF     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      GRANT = 2'd2
   } state_t;

   localparam logic REQ_PLAYER = 1'b0;
   localparam logic REQ_ENEMY  = 1'b1;

endpackage

// File: rtl/spawn_slot_scheduler_if.sv
// Request/grant bundle between the two spawn requesters and the slot scheduler.
interface spawn_slot_scheduler_if #(
   parameter int NSLOT  = 4,
   parameter int SLOT_W = 2
);
   // req[i] is a level held until grant[i] pulses for one cycle; release_vld is a one-cycle pulse.
   logic                tick;
   logic [1:0]          req;
   logic                release_vld;
   logic [SLOT_W-1:0]   release_slot;
   logic [1:0]          grant;
   logic [SLOT_W-1:0]   grant_slot;
   logic [NSLOT-1:0]    slot_active;
   logic [NSLOT-1:0]    slot_owner;
   logic                full;
   logic [1:0]          cd_busy;
   spawn_pkg::state_t   state;

   modport master (
      output tick, req, release_vld, release_slot,
      input  grant, grant_slot, slot_active, slot_owner, full, cd_busy, state
   );

   modport slave (
      input  tick, req, release_vld, release_slot,
      output grant, grant_slot, slot_active, slot_owner, full, cd_busy, state
   );
endinterface

// File: rtl/spawn_slot_scheduler_cooldown.sv
// Per-requester cooldown: loads on grant, counts down on game ticks, busy while nonzero.
module spawn_cooldown #(
   parameter int COOLDOWN = 8,
   parameter int CD_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   output logic busy
);
   logic [CD_W-1:0] cnt;

   // A load in the same cycle as a tick takes priority so the full cooldown is served.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CD_W'(COOLDOWN);
      end else if (tick && cnt != '0) begin
         cnt <= cnt - CD_W'(1);
      end
   end

   assign busy = (cnt != '0);
endmodule

// File: rtl/spawn_slot_scheduler.sv
// Round-robin spawn arbiter onto a pool of sprite slots with per-requester cooldown.
// Optional build macro OWNER_CAP_EN limits each requester to NSLOT/2 active slots.
module spawn_slot_scheduler
   import spawn_pkg::*;
#(
   parameter int NSLOT    = NSLOT_DEF,
   parameter int SLOT_W   = SLOT_W_DEF,
   parameter int COOLDOWN = COOLDOWN_DEF,
   parameter int CD_W     = CD_W_DEF
) (
   input logic                  clk,
   input logic                  rst,
   spawn_slot_scheduler_if.slave bus
);
   state_t            state;
   logic              winner;
   logic              last_winner;
   logic [NSLOT-1:0]  active_q, owner_q;
   logic [NSLOT-1:0]  active_nxt, owner_nxt;
   logic              full_q;
   logic [1:0]        grant_q;
   logic [SLOT_W-1:0] grant_slot_q;
   logic [SLOT_W-1:0] free_idx;
   logic              any_free;
   logic [1:0]        cd_load, cd_busy, capped, eligible;

   // Lowest free slot, taken from the registered mask so a slot freed this cycle is not reused yet.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            free_idx = SLOT_W'(i);
            any_free = 1'b1;
         end
      end
   end

`ifdef OWNER_CAP_EN
   int own_cnt [2];
   always_comb begin
      own_cnt[0] = 0;
      own_cnt[1] = 0;
      for (int i = 0; i < NSLOT; i++) begin
         if (active_q[i]) own_cnt[owner_q[i]] = own_cnt[owner_q[i]] + 1;
      end
   end
   assign capped[REQ_PLAYER] = (own_cnt[REQ_PLAYER] >= NSLOT / 2);
   assign capped[REQ_ENEMY]  = (own_cnt[REQ_ENEMY]  >= NSLOT / 2);
`else
   assign capped = 2'b00;
`endif

   assign eligible = bus.req & ~cd_busy & ~capped;

   // Release and allocation may land on different slots in the same cycle; both apply.
   always_comb begin
      active_nxt = active_q;
      owner_nxt  = owner_q;
      if (bus.release_vld) begin
         active_nxt[bus.release_slot] = 1'b0;
         owner_nxt[bus.release_slot]  = 1'b0;
      end
      if (state == ALLOC && any_free) begin
         active_nxt[free_idx] = 1'b1;
         owner_nxt[free_idx]  = winner;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         winner       <= REQ_PLAYER;
         last_winner  <= REQ_ENEMY;
         active_q     <= '0;
         owner_q      <= '0;
         full_q       <= 1'b0;
         grant_q      <= 2'b00;
         grant_slot_q <= '0;
      end else begin
         active_q <= active_nxt;
         owner_q  <= owner_nxt;
         full_q   <= &active_nxt;
         grant_q  <= 2'b00;
         case (state)
            IDLE: begin
               if (|eligible && !full_q) begin
                  winner <= (eligible == 2'b11) ? ~last_winner : eligible[REQ_ENEMY];
                  state  <= ALLOC;
               end
            end
            ALLOC: begin
               if (any_free) begin
                  grant_slot_q     <= free_idx;
                  grant_q[winner]  <= 1'b1;
                  state            <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               last_winner <= winner;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cd_load[REQ_PLAYER] = (state == GRANT) && (winner == REQ_PLAYER);
   assign cd_load[REQ_ENEMY]  = (state == GRANT) && (winner == REQ_ENEMY);

   spawn_cooldown #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_cd_player (
      .clk  (clk),
      .rst  (rst),
      .load (cd_load[REQ_PLAYER]),
      .tick (bus.tick),
      .busy (cd_busy[REQ_PLAYER])
   );

   spawn_cooldown #(.COOLDOWN(COOLDOWN), .CD_W(CD_W)) u_cd_enemy (
      .clk  (clk),
      .rst  (rst),
      .load (cd_load[REQ_ENEMY]),
      .tick (bus.tick),
      .busy (cd_busy[REQ_ENEMY])
   );

   assign bus.grant       = grant_q;
   assign bus.grant_slot  = grant_slot_q;
   assign bus.slot_active = active_q;
   assign bus.slot_owner  = owner_q;
   assign bus.full        = full_q;
   assign bus.cd_busy     = cd_busy;
   assign bus.state       = state;
endmodule

// File: tb/tb_spawn_slot_scheduler.sv
// Bench for spawn_slot_scheduler: spec-level model checked every cycle plus hand-computed directed expectations.
module tb_spawn_slot_scheduler;
   import spawn_pkg::*;

   localparam int NSLOT    = 4;
   localparam int SLOT_W   = 2;
   localparam int COOLDOWN = 3;
   localparam int CD_W     = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   spawn_slot_scheduler_if #(.NSLOT(NSLOT), .SLOT_W(SLOT_W)) bus ();

   spawn_slot_scheduler #(
      .NSLOT(NSLOT), .SLOT_W(SLOT_W), .COOLDOWN(COOLDOWN), .CD_W(CD_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit [NSLOT-1:0]    m_act   = '0;
   bit [NSLOT-1:0]    m_own   = '0;
   int                m_cd [2] = '{0, 0};
   bit                m_last  = 1'b1;
   bit                m_win   = 1'b0;
   int                m_phase = 0;   // 0 waiting, 1 winner chosen, 2 grant showing
   bit [1:0]          m_grant = 2'b00;
   logic [SLOT_W:0]   exp_q [$];

   task automatic model_reset();
      m_act = '0; m_own = '0; m_cd = '{0, 0};
      m_last = 1'b1; m_win = 1'b0; m_phase = 0; m_grant = 2'b00;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit [1:0]       elig;
      bit [NSLOT-1:0] nact, nown;
      int             ncd [2];
      int             slot;
`ifdef OWNER_CAP_EN
      int             owned [2];
      owned = '{0, 0};
      for (int i = 0; i < NSLOT; i++) if (m_act[i]) owned[m_own[i]]++;
`endif
      for (int r = 0; r < 2; r++) begin
         elig[r] = bus.req[r] && (m_cd[r] == 0);
`ifdef OWNER_CAP_EN
         if (owned[r] >= NSLOT / 2) elig[r] = 1'b0;
`endif
         if (m_phase == 2 && int'(m_win) == r) ncd[r] = COOLDOWN;
         else if (bus.tick && m_cd[r] > 0)     ncd[r] = m_cd[r] - 1;
         else                                  ncd[r] = m_cd[r];
      end
      nact = m_act;
      nown = m_own;
      if (bus.release_vld) begin
         nact[bus.release_slot] = 1'b0;
         nown[bus.release_slot] = 1'b0;
      end
      m_grant = 2'b00;
      case (m_phase)
         0: begin
            if (elig != 2'b00 && m_act != '1) begin
               m_win   = (elig == 2'b11) ? !m_last : elig[1];
               m_phase = 1;
            end
         end
         1: begin
            slot = -1;
            for (int i = NSLOT - 1; i >= 0; i--) if (!m_act[i]) slot = i;
            if (slot >= 0) begin
               nact[slot] = 1'b1;
               nown[slot] = m_win;
               m_grant[m_win] = 1'b1;
               exp_q.push_back({m_win, SLOT_W'(slot)});
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end
         default: begin
            m_last  = m_win;
            m_phase = 0;
         end
      endcase
      m_act = nact;
      m_own = nown;
      m_cd  = ncd;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [SLOT_W:0] e;
      check("grant", bus.grant, 8'(m_grant));
      if (m_grant != 2'b00 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("grant_slot", 8'(bus.grant_slot), 8'(e[SLOT_W-1:0]));
      end
      check("slot_active", 8'(bus.slot_active), 8'(m_act));
      check("slot_owner",  8'(bus.slot_owner),  8'(m_own));
      check("full",        8'(bus.full),        8'(&m_act));
      check("cd_busy",     8'(bus.cd_busy),     {6'd0, m_cd[1] != 0, m_cd[0] != 0});
   end

   // ---------------- driver tasks ----------------
   task automatic tick_pulse();
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
   endtask

   task automatic release_pulse(input int slot);
      bus.release_vld  = 1'b1;
      bus.release_slot = SLOT_W'(slot);
      @(negedge clk);
      bus.release_vld  = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      bit              seen;
      int              n_g;
      logic [3:0]      wins;
      logic [7:0]      slots;

      bus.tick = 1'b0; bus.req = 2'b00; bus.release_vld = 1'b0; bus.release_slot = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_grant",  bus.grant, 8'h00);
      check("rst_active", 8'(bus.slot_active), 8'h00);
      check("rst_cd",     8'(bus.cd_busy), 8'h00);
      rst = 1'b1;

      // first grant: player, slot 0
      @(negedge clk);
      bus.req = 2'b01;
      repeat (2) @(negedge clk);
      check("first_grant",  8'(bus.grant), 8'h01);
      check("first_slot",   8'(bus.grant_slot), 8'h00);
      check("first_active", 8'(bus.slot_active), 8'h01);
      check("first_owner",  8'(bus.slot_owner), 8'h00);
      @(negedge clk);
      check("first_cd", 8'(bus.cd_busy), 8'h01);

      // player reissues at once: blocked until the third tick
      tick_pulse(); @(negedge clk);
      tick_pulse(); @(negedge clk);
      check("cd_still_busy", 8'(bus.cd_busy), 8'h01);
      tick_pulse();
      check("cd_clear", 8'(bus.cd_busy), 8'h00);
      repeat (2) @(negedge clk);
      check("cd_grant", 8'(bus.grant), 8'h01);
      check("cd_slot",  8'(bus.grant_slot), 8'h01);
      bus.req = 2'b00;
      @(negedge clk);

      // release of an inactive slot is ignored
      release_pulse(3);
      check("rel_inactive_active", 8'(bus.slot_active), 8'h03);

      // release slot 0 while slot 1 is being allocated to the enemy
      release_pulse(1);
      bus.req = 2'b10;
      @(negedge clk);
      release_pulse(0);
      check("rel_alloc_grant",  8'(bus.grant), 8'h02);
      check("rel_alloc_slot",   8'(bus.grant_slot), 8'h01);
      check("rel_alloc_active", 8'(bus.slot_active), 8'h02);
      check("rel_alloc_owner",  8'(bus.slot_owner), 8'h02);
      bus.req = 2'b00;

      // clear cooldowns, then reset in the middle of ALLOC
      bus.tick = 1'b1;
      repeat (5) @(negedge clk);
      bus.tick = 1'b0;
      bus.req = 2'b01;
      @(posedge clk);
      #2;
      check("in_alloc", 8'(bus.state), 8'(ALLOC));
      rst = 1'b0;
      #1;
      check("midrst_grant",  8'(bus.grant), 8'h00);
      check("midrst_active", 8'(bus.slot_active), 8'h00);
      check("midrst_owner",  8'(bus.slot_owner), 8'h00);
      check("midrst_full",   8'(bus.full), 8'h00);
      bus.req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.grant != 2'b00) seen = 1'b1;
      end
      check("no_grant_after_rst", 8'(seen), 8'h00);

      // tie: both requesting, tick every cycle
      bus.tick = 1'b1;
      bus.req  = 2'b11;
      n_g = 0; wins = '0; slots = '0;
      for (int k = 0; k < 40 && n_g < 4; k++) begin
         @(negedge clk);
         if (bus.grant != 2'b00) begin
            wins[n_g] = bus.grant[1];
            slots[n_g*2 +: 2] = bus.grant_slot;
            n_g++;
         end
      end
      bus.req = 2'b00;
      check("tie_count", 8'(n_g), 8'd4);
      check("tie_winners", 8'(wins), 8'h0A);
      check("tie_slots", slots, 8'hE4);
      check("tie_full", 8'(bus.full), 8'h01);
      check("tie_owner", 8'(bus.slot_owner), 8'h0A);

      // full with a pending player request
      @(negedge clk);
      bus.req = 2'b01;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.grant != 2'b00) seen = 1'b1;
      end
      check("full_no_grant", 8'(seen), 8'h00);
      release_pulse(2);
      check("full_rel_active", 8'(bus.slot_active), 8'h0B);
      check("full_rel_full",   8'(bus.full), 8'h00);
      @(negedge clk);
      check("full_rel_wait", 8'(bus.grant), 8'h00);
      @(negedge clk);
      check("full_rel_grant", 8'(bus.grant), 8'h01);
      check("full_rel_slot",  8'(bus.grant_slot), 8'h02);
      bus.req = 2'b00;
      @(negedge clk);

`ifdef OWNER_CAP_EN
      // player holds slots 0 and 2 (its cap); only the enemy can win
      release_pulse(3);
      bus.req = 2'b01;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.grant != 2'b00) seen = 1'b1;
      end
      check("cap_blocked", 8'(seen), 8'h00);
      bus.req = 2'b11;
      n_g = 0; wins = '0; slots = '0;
      for (int k = 0; k < 10 && n_g < 1; k++) begin
         @(negedge clk);
         if (bus.grant != 2'b00) begin
            wins[0]   = bus.grant[1];
            slots[1:0] = bus.grant_slot;
            n_g++;
         end
      end
      bus.req = 2'b00;
      check("cap_count",  8'(n_g), 8'd1);
      check("cap_winner", 8'(wins), 8'h01);
      check("cap_slot",   slots, 8'h03);
`endif

      bus.tick = 1'b0;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
